hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS core. It decides each cycle whether the F and D stages freeze and whether the D→E register is loaded with the decoded instruction or with a bubble. It compares register-use deadlines (Tuse) against result-ready times (Tnew) held in the E and M stages, and tracks the multiply/divide unit's busy window with an internal countdown. It also orders `eret` after in-flight EPC writes. It drives the enable and flush inputs of the F→D and D→E pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_ctrl_mdu_busy_tracker.sv | 48 ++++
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller.
// The optional stall-cycle performance counter is enabled with HAZARD_CTRL_PERF_EN.
package hazard_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam logic [3:0] TUSE_NONE      = 4'hF;
    localparam int         DEF_MULT_CYCLES = 5;
    localparam int         DEF_DIV_CYCLES  = 10;

    // True when the opcode occupies the MDU for the multiply latency.
    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    // True when the opcode occupies the MDU for the divide latency.
    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_tracker.sv
// Tracks the multiply/divide unit busy window with a 4-bit down-counter.
// A start issued alongside Req belongs to a cancelled instruction and is ignored;
// Req never clears a countdown already running.
module mdu_busy_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Req,
    input  logic       E_MDU_start,
    input  logic [3:0] E_MDUop,
    output logic       MDU_busy
);

    if (MULT_CYCLES > 15 || MULT_CYCLES < 0) begin : g_bad_mult
        $error("MULT_CYCLES must fit in 4 bits");
    end
    if (DIV_CYCLES > 15 || DIV_CYCLES < 0) begin : g_bad_div
        $error("DIV_CYCLES must fit in 4 bits");
    end

    logic [3:0] cnt;
    logic       start_ok;

    assign start_ok = E_MDU_start & ~Req;

    // Load on a valid start (reloading if already busy), otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (start_ok && is_mult(E_MDUop)) begin
            cnt <= 4'(MULT_CYCLES);
        end else if (start_ok && is_div(E_MDUop)) begin
            cnt <= 4'(DIV_CYCLES);
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Busy covers the issue cycle itself plus every cycle the counter is non-zero.
    always_comb begin
        MDU_busy = start_ok | (cnt != 4'd0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: GRF Tuse/Tnew stalls, MDU busy stalls and eret
// ordering behind EPC writes. Define HAZARD_CTRL_PERF_EN to add stall_cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [3:0]  D_rs_Tuse,
    input  logic [3:0]  D_rt_Tuse,
    input  logic        D_MDU_use,
    input  logic        D_eret,
    input  logic [4:0]  E_GRF_A3,
    input  logic [4:0]  M_GRF_A3,
    input  logic        E_GRF_write,
    input  logic        M_GRF_write,
    input  logic [3:0]  E_Tnew,
    input  logic [3:0]  M_Tnew,
    input  logic        E_MDU_start,
    input  logic [3:0]  E_MDUop,
    input  logic        E_EPC_write,
    input  logic        M_EPC_write,
    output logic        F_PC_EN,
    output logic        F_D_REG_EN,
    output logic        D_E_REG_EN,
    output logic        D_E_flush,
    output logic        MDU_busy,
    output logic        stall
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic rs_stall;
    logic rt_stall;
    logic mdu_stall;
    logic eret_stall;

    mdu_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .E_MDU_start (E_MDU_start),
        .E_MDUop     (E_MDUop),
        .MDU_busy    (MDU_busy)
    );

    // Source operands stall while an older producer's result arrives after its use deadline.
    // A Tuse of TUSE_NONE can never be exceeded by a 4-bit Tnew, so unused operands fall out.
    always_comb begin
        rs_stall = (D_rs_addr != 5'd0) &&
                   ((E_GRF_write && (E_GRF_A3 == D_rs_addr) && (E_Tnew > D_rs_Tuse)) ||
                    (M_GRF_write && (M_GRF_A3 == D_rs_addr) && (M_Tnew > D_rs_Tuse)));
        rt_stall = (D_rt_addr != 5'd0) &&
                   ((E_GRF_write && (E_GRF_A3 == D_rt_addr) && (E_Tnew > D_rt_Tuse)) ||
                    (M_GRF_write && (M_GRF_A3 == D_rt_addr) && (M_Tnew > D_rt_Tuse)));
        mdu_stall  = D_MDU_use & MDU_busy;
        eret_stall = D_eret & (E_EPC_write | M_EPC_write);
    end

    // Freeze F/D and bubble E on any hazard; an exception request overrides everything.
    always_comb begin
        stall      = (rs_stall | rt_stall | mdu_stall | eret_stall) & ~Req;
        F_PC_EN    = ~stall;
        F_D_REG_EN = ~stall;
        D_E_REG_EN = 1'b1;
        D_E_flush  = stall;
    end

`ifdef HAZARD_CTRL_PERF_EN
    // Count stalled cycles, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default latencies 5/10).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [4:0]  D_rs_addr, D_rt_addr;
    logic [3:0]  D_rs_Tuse, D_rt_Tuse;
    logic        D_MDU_use, D_eret;
    logic [4:0]  E_GRF_A3, M_GRF_A3;
    logic        E_GRF_write, M_GRF_write;
    logic [3:0]  E_Tnew, M_Tnew;
    logic        E_MDU_start;
    logic [3:0]  E_MDUop;
    logic        E_EPC_write, M_EPC_write;
    logic        F_PC_EN, F_D_REG_EN, D_E_REG_EN, D_E_flush, MDU_busy, stall;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] perf_base;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_rs_Tuse   (D_rs_Tuse),
        .D_rt_Tuse   (D_rt_Tuse),
        .D_MDU_use   (D_MDU_use),
        .D_eret      (D_eret),
        .E_GRF_A3    (E_GRF_A3),
        .M_GRF_A3    (M_GRF_A3),
        .E_GRF_write (E_GRF_write),
        .M_GRF_write (M_GRF_write),
        .E_Tnew      (E_Tnew),
        .M_Tnew      (M_Tnew),
        .E_MDU_start (E_MDU_start),
        .E_MDUop     (E_MDUop),
        .E_EPC_write (E_EPC_write),
        .M_EPC_write (M_EPC_write),
        .F_PC_EN     (F_PC_EN),
        .F_D_REG_EN  (F_D_REG_EN),
        .D_E_REG_EN  (D_E_REG_EN),
        .D_E_flush   (D_E_flush),
        .MDU_busy    (MDU_busy),
        .stall       (stall)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req = 0; D_rs_addr = 0; D_rt_addr = 0;
        D_rs_Tuse = TUSE_NONE; D_rt_Tuse = TUSE_NONE;
        D_MDU_use = 0; D_eret = 0;
        E_GRF_A3 = 0; M_GRF_A3 = 0; E_GRF_write = 0; M_GRF_write = 0;
        E_Tnew = 0; M_Tnew = 0; E_MDU_start = 0; E_MDUop = MDU_NONE;
        E_EPC_write = 0; M_EPC_write = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check("rst_cnt", 32'(dut.u_mdu.cnt), 0);
        check("rst_busy", 32'(MDU_busy), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_pc_en", 32'(F_PC_EN), 1);
`ifdef HAZARD_CTRL_PERF_EN
        check("rst_perf", stall_cycles, 0);
`endif

        // E-stage load-use
        E_GRF_write = 1; E_GRF_A3 = 8; E_Tnew = 2; D_rs_addr = 8; D_rs_Tuse = 0;
        #1;
        check("lu_stall", 32'(stall), 1);
        check("lu_pc_en", 32'(F_PC_EN), 0);
        check("lu_fd_en", 32'(F_D_REG_EN), 0);
        check("lu_de_en", 32'(D_E_REG_EN), 1);
        check("lu_flush", 32'(D_E_flush), 1);

        // Req overrides the stall
        Req = 1; #1;
        check("req_stall", 32'(stall), 0);
        check("req_pc_en", 32'(F_PC_EN), 1);
        check("req_fd_en", 32'(F_D_REG_EN), 1);
        check("req_de_en", 32'(D_E_REG_EN), 1);
        check("req_flush", 32'(D_E_flush), 0);
        Req = 0;

        E_Tnew = 0; #1;
        check("tnew0", 32'(stall), 0);
        E_Tnew = 1; D_rs_Tuse = 1; #1;
        check("tnew_eq_tuse", 32'(stall), 0);
        D_rs_Tuse = 0; #1;
        check("tnew_gt_tuse", 32'(stall), 1);
        D_rs_Tuse = TUSE_NONE; E_Tnew = 2; #1;
        check("tuse_none", 32'(stall), 0);
        D_rs_addr = 0; E_GRF_A3 = 0; D_rs_Tuse = 0; #1;
        check("reg_zero", 32'(stall), 0);
        D_rs_addr = 8; E_GRF_A3 = 8; E_GRF_write = 0; #1;
        check("no_write", 32'(stall), 0);

        // M-stage producer, rt side
        idle_inputs();
        M_GRF_write = 1; M_GRF_A3 = 5; M_Tnew = 1; D_rt_addr = 5; D_rt_Tuse = 0;
        #1;
        check("m_rt_stall", 32'(stall), 1);
        D_rt_addr = 6; #1;
        check("m_rt_diff_reg", 32'(stall), 0);

        // div countdown with mflo held in D
        idle_inputs();
        D_MDU_use = 1; E_MDU_start = 1; E_MDUop = MDU_DIV;
        #1;
        check("div_t_busy", 32'(MDU_busy), 1);
        check("div_t_stall", 32'(stall), 1);
        tick();
        E_MDU_start = 0; E_MDUop = MDU_MFLO;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check($sformatf("div_cnt_%0d", k), 32'(dut.u_mdu.cnt), 32'(11 - k));
            check($sformatf("div_stall_%0d", k), 32'(stall), 1);
            tick();
        end
        check("div_release", 32'(stall), 0);
        check("div_cnt_end", 32'(dut.u_mdu.cnt), 0);
        check("div_busy_end", 32'(MDU_busy), 0);

        // mult load, Req during countdown, reset during countdown
        idle_inputs();
        E_MDU_start = 1; E_MDUop = MDU_MULTU;
        tick();
        E_MDU_start = 0;
        #1;
        check("mult_cnt", 32'(dut.u_mdu.cnt), 5);
        Req = 1;
        tick();
        check("req_keeps_cnt", 32'(dut.u_mdu.cnt), 4);
        check("req_keeps_busy", 32'(MDU_busy), 1);
        Req = 0;
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rst_mid_cnt", 32'(dut.u_mdu.cnt), 0);

        // start coinciding with Req is dropped
        E_MDU_start = 1; E_MDUop = MDU_DIVU; Req = 1;
        #1;
        check("req_start_busy", 32'(MDU_busy), 0);
        tick();
        E_MDU_start = 0; Req = 0;
        #1;
        check("req_start_cnt", 32'(dut.u_mdu.cnt), 0);
        check("req_start_busy_nx", 32'(MDU_busy), 0);

        // reload while busy
        E_MDU_start = 1; E_MDUop = MDU_MULT;
        tick();
        E_MDU_start = 0;
        tick();
        E_MDU_start = 1; E_MDUop = MDU_DIV;
        tick();
        E_MDU_start = 0;
        #1;
        check("reload_cnt", 32'(dut.u_mdu.cnt), 10);
        do_reset();

        // eret ordered behind EPC writes
        idle_inputs();
        D_eret = 1; E_EPC_write = 1; #1;
        check("eret_e_stall", 32'(stall), 1);
        E_EPC_write = 0; M_EPC_write = 1; #1;
        check("eret_m_stall", 32'(stall), 1);
`ifdef HAZARD_CTRL_PERF_EN
        perf_base = stall_cycles;
`endif
        tick();
        M_EPC_write = 0; #1;
        check("eret_release", 32'(stall), 0);
`ifdef HAZARD_CTRL_PERF_EN
        check("perf_inc1", stall_cycles, perf_base + 32'd1);
        tick();
        check("perf_hold", stall_cycles, perf_base + 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
